// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: RX byte-lane comma lock and 8-to-32 packer sequencing.
// Hunts for LOCK_COUNT consecutive comma symbols, then qualifies data bytes
// into 4-byte words for the packer. Lock is dropped after LOSS_COUNT
// consecutive error events without a clean word or idle comma in between.
// Optional feature macro: RX_SYNC_ERRCNT_EN enables the saturating err_count.
module rx_sync_ctrl #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       active,
  output logic       shift_en,
  output logic [7:0] byte_out,
  output logic [1:0] phase,
  output logic       word_done,
  output logic       word_abort,
  output logic [7:0] err_count
);

  localparam int COM_W = $clog2(LOCK_COUNT) + 1;
  localparam int ERR_W = $clog2(LOSS_COUNT) + 1;
  localparam logic [COM_W-1:0] COM_MAX  = COM_W'(LOCK_COUNT);
  localparam logic [COM_W-1:0] COM_LAST = COM_W'(LOCK_COUNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(LOSS_COUNT);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [COM_W-1:0] r_com_cnt;
  logic [ERR_W-1:0] r_err_run;
  logic [1:0]       r_phase;      // position of the next data byte in the word

  logic             r_active;
  logic             r_shift_en;
  logic [7:0]       r_byte_out;
  logic [1:0]       r_phase_out;
  logic             r_word_done;
  logic             r_word_abort;

  logic w_com;
  logic w_data;
  logic w_err_event;

  assign w_com  = valid_in && (data_in == COM_SYMBOL);
  assign w_data = valid_in && (data_in != COM_SYMBOL);
  // In lock, anything that is neither a data byte nor an idle comma at a
  // word boundary counts as an error event.
  assign w_err_event = (r_state == ST_LOCKED) && !w_data &&
                       !((r_phase == 2'd0) && w_com);

  // Sync FSM with registered outputs; every output reflects the byte sampled at this edge.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_SEARCH;
      r_com_cnt    <= '0;
      r_err_run    <= '0;
      r_phase      <= 2'd0;
      r_active     <= 1'b0;
      r_shift_en   <= 1'b0;
      r_byte_out   <= 8'd0;
      r_phase_out  <= 2'd0;
      r_word_done  <= 1'b0;
      r_word_abort <= 1'b0;
    end else begin
      r_byte_out   <= data_in;
      r_shift_en   <= 1'b0;
      r_word_done  <= 1'b0;
      r_word_abort <= 1'b0;
      r_phase_out  <= 2'd0;
      case (r_state)
        ST_SEARCH: begin
          if (w_com) begin
            r_state   <= ST_CHECK;
            r_com_cnt <= COM_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_com) begin
            if (r_com_cnt >= COM_LAST) begin
              r_state   <= ST_LOCKED;
              r_com_cnt <= COM_MAX;
              r_phase   <= 2'd0;
              r_err_run <= '0;
              r_active  <= 1'b1;
            end else begin
              r_com_cnt <= r_com_cnt + COM_W'(1);
            end
          end else if (w_data) begin
            r_state   <= ST_SEARCH;
            r_com_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_data) begin
            r_shift_en  <= 1'b1;
            r_phase_out <= r_phase;
            r_phase     <= r_phase + 2'd1;
            if (r_phase == 2'd3) begin
              r_word_done <= 1'b1;
              r_err_run   <= '0;
            end
          end else if (!w_err_event) begin
            // Idle comma between words: the link is healthy.
            r_err_run <= '0;
          end else begin
            // Abort any partial word; a loss on the same byte also applies.
            r_word_abort <= (r_phase != 2'd0);
            r_phase      <= 2'd0;
            if (r_err_run >= ERR_LAST) begin
              r_state   <= ST_SEARCH;
              r_active  <= 1'b0;
              r_com_cnt <= '0;
              r_err_run <= ERR_MAX;
            end else begin
              r_err_run <= r_err_run + ERR_W'(1);
            end
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign active     = r_active;
  assign shift_en   = r_shift_en;
  assign byte_out   = r_byte_out;
  assign phase      = r_phase_out;
  assign word_done  = r_word_done;
  assign word_abort = r_word_abort;

`ifdef RX_SYNC_ERRCNT_EN
  logic [7:0] r_err_count;
  logic       w_check_break;

  assign w_check_break = (r_state == ST_CHECK) && w_data;

  // Saturating lifetime count of lock errors and broken acquisitions.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_err_count <= 8'd0;
    end else if ((w_err_event || w_check_break) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Self-checking bench for rx_sync_ctrl: directed scenarios followed by
// biased random traffic, all compared against a word-queue reference model.
module tb_rx_sync_ctrl;

  localparam logic [7:0] COM = 8'hBC;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;
`ifdef RX_SYNC_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       active, shift_en, word_done, word_abort;
  logic [7:0] byte_out, err_count;
  logic [1:0] phase;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: lock flag, comma run, error run, partial word.
  bit         m_locked;
  int         m_commas;
  int         m_errs;
  int         m_errcnt;
  logic [7:0] m_word[$];

  // Expected outputs after the most recent edge.
  bit         e_active, e_shift, e_done, e_abort;
  logic [7:0] e_byte;
  int         e_phase;

  rx_sync_ctrl #(.COM_SYMBOL(COM), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .active    (active),
    .shift_en  (shift_en),
    .byte_out  (byte_out),
    .phase     (phase),
    .word_done (word_done),
    .word_abort(word_abort),
    .err_count (err_count)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_locked = 0; m_commas = 0; m_errs = 0; m_errcnt = 0;
    m_word.delete();
    e_active = 0; e_shift = 0; e_done = 0; e_abort = 0; e_byte = 8'd0; e_phase = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    bit is_com, is_dat;
    is_com = v && (d == COM);
    is_dat = v && (d != COM);
    e_shift = 0; e_done = 0; e_abort = 0; e_phase = 0; e_byte = d;
    if (!m_locked) begin
      if (is_com) begin
        m_commas++;
        if (m_commas >= LOCK_N) begin
          m_locked = 1; m_errs = 0; m_word.delete();
        end
      end else if (is_dat) begin
        if (m_commas > 0) m_errcnt++;
        m_commas = 0;
      end
    end else begin
      if (is_dat) begin
        e_shift = 1;
        e_phase = m_word.size();
        m_word.push_back(d);
        if (m_word.size() == 4) begin
          e_done = 1; m_word.delete(); m_errs = 0;
        end
      end else if (is_com && m_word.size() == 0) begin
        m_errs = 0;
      end else begin
        e_abort = (m_word.size() != 0);
        m_word.delete();
        m_errs++;
        m_errcnt++;
        if (m_errs >= LOSS_N) begin
          m_locked = 0; m_commas = 0;
        end
      end
    end
    e_active = m_locked;
  endtask

  task automatic check_all();
    int exp_cnt;
    exp_cnt = ERRCNT_EN ? ((m_errcnt > 255) ? 255 : m_errcnt) : 0;
    chk("active", active, e_active);
    chk("shift_en", shift_en, e_shift);
    chk("byte_out", byte_out, e_byte);
    chk("word_done", word_done, e_done);
    chk("word_abort", word_abort, e_abort);
    chk("err_count", err_count, exp_cnt);
    if (e_shift) chk("phase", phase, e_phase);
  endtask

  task automatic cycle(input bit v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    model_step(v, d);
    #1;
    check_all();
    $display("t=%0t v=%0b d=%02h -> act=%0b sh=%0b ph=%0d bo=%02h wd=%0b wa=%0b ec=%0d",
             $time, v, d, active, shift_en, phase, byte_out, word_done, word_abort, err_count);
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, holds across one edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_active", active, 0);
    chk("rst_shift", shift_en, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_phase", phase, 0);
    chk("rst_done", word_done, 0);
    chk("rst_abort", word_abort, 0);
    chk("rst_errcnt", err_count, 0);
    model_reset();
    @(posedge clk_4f);
    #1;
    chk("rst_hold_active", active, 0);
    reset = 1'b1;
  endtask

  initial begin
    int com_pct, val_pct;
    bit v;
    logic [7:0] d;

    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    #2;
    do_reset();

    // Lock acquisition: three commas are not enough, the fourth locks.
    for (int i = 0; i < 3; i++) cycle(1, COM);
    chk("lock_early", active, 0);
    cycle(1, COM);
    chk("lock_active", active, 1);
    chk("lock_noshift", shift_en, 0);

    // Broken acquisition from a fresh reset.
    do_reset();
    cycle(1, COM); cycle(1, COM); cycle(1, 8'h55);
    chk("broken_nolock", active, 0);
    for (int i = 0; i < 3; i++) cycle(1, COM);
    chk("broken_early", active, 0);
    cycle(1, COM);
    chk("broken_lock", active, 1);
    chk("broken_errcnt", err_count, ERRCNT_EN ? 32'd1 : 32'd0);

    // Word sequencing.
    cycle(1, 8'h11); chk("w0_phase", phase, 0);
    cycle(1, 8'h22); chk("w1_phase", phase, 1);
    cycle(1, 8'h33); chk("w2_phase", phase, 2);
    cycle(1, 8'h44);
    chk("w3_phase", phase, 3);
    chk("w3_byte", byte_out, 8'h44);
    chk("w3_done", word_done, 1);

    // Abort mid-word, then a fresh word starts at phase 0.
    cycle(1, 8'h11); cycle(1, 8'h22); cycle(0, 8'h00);
    chk("abort_pulse", word_abort, 1);
    chk("abort_noshift", shift_en, 0);
    cycle(1, 8'h77);
    chk("abort_next_shift", shift_en, 1);
    chk("abort_next_phase", phase, 0);
    chk("abort_active", active, 1);
    cycle(1, 8'h22); cycle(1, 8'h33); cycle(1, 8'h44);

    // Loss of lock after four invalid bytes at a word boundary.
    for (int i = 0; i < 3; i++) cycle(0, 8'h00);
    chk("loss_early", active, 1);
    cycle(0, 8'h00);
    chk("loss_active", active, 0);
    cycle(1, 8'h12);
    chk("loss_noshift", shift_en, 0);

    // Reset mid-word at phase 2, then four commas to relock.
    for (int i = 0; i < 4; i++) cycle(1, COM);
    cycle(1, 8'hA1); cycle(1, 8'hA2);
    do_reset();
    chk("midrst_abort", word_abort, 0);
    for (int i = 0; i < 3; i++) cycle(1, COM);
    chk("relock_early", active, 0);
    cycle(1, COM);
    chk("relock_active", active, 1);

    // Biased random traffic in segments with varying comma/valid density.
    for (int seg = 0; seg < 10; seg++) begin
      com_pct = $urandom_range(10, 70);
      val_pct = $urandom_range(60, 100);
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 599) == 0) do_reset();
        v = ($urandom_range(1, 100) <= val_pct);
        d = ($urandom_range(1, 100) <= com_pct) ? COM : 8'($urandom);
        cycle(v, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_sync_ctrl.md
# rx_sync_ctrl

Receive-lane synchronisation and sequencing controller for the PHY RX byte path. It watches the incoming byte stream for the comma symbol and acquires lock after a run of consecutive commas. Once locked, it qualifies data bytes and drives the shift, phase and word-boundary controls of the downstream 8-to-32 packer. It drops lock after repeated error events, so the packer only ever sees byte-aligned, complete words.

## Interface
- COM_SYMBOL, 8'hBC, comma/idle symbol.
- LOCK_COUNT, 4, consecutive valid commas required to lock; must be at least 2.
- LOSS_COUNT, 4, consecutive error events that drop lock; must be at least 1.

Ports:
- clk_4f  in  1  byte clock; the only clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  in  8  received byte.
- valid_in  in  1  data_in qualifier.
- active  out  1  lane locked.
- shift_en  out  1  one-cycle strobe: byte_out is a data byte for the packer.
- byte_out  out  8  registered copy of data_in.
- phase  out  2  index of byte_out within the word; 0 = first byte.
- word_done  out  1  strobe coincident with the shift_en of the phase-3 byte.
- word_abort  out  1  strobe: partial word discarded.
- err_count  out  8  saturating total error-event count (see Configuration).

## Operation
- States: SEARCH, CHECK, LOCKED. Reset enters SEARCH and clears all counters.
- SEARCH:
  - Valid COM -> CHECK, with com_cnt = 1.
  - Anything else -> stay in SEARCH.
- CHECK:
  - Valid COM -> com_cnt + 1. When com_cnt reaches LOCK_COUNT -> LOCKED, with phase = 0 and err_run = 0.
  - Valid non-COM -> SEARCH, with com_cnt = 0.
  - valid_in = 0 -> hold state and com_cnt.
- LOCKED, phase 0:
  - Valid COM -> idle: no strobe, err_run = 0.
  - Valid non-COM -> shift_en with phase 0; next phase = 1.
  - valid_in = 0 -> error event.
- LOCKED, phase 1-3:
  - Valid non-COM -> shift_en with the current phase; phase increments.
  - At phase 3 the shift also asserts word_done, phase wraps to 0, and err_run = 0.
  - Valid COM or valid_in = 0 -> error event plus word_abort; phase -> 0. No shift_en for that byte.
- Error event:
  - err_run + 1. If err_run reaches LOSS_COUNT -> SEARCH, with active = 0, phase = 0 and com_cnt = 0.
  - The abort and the loss can occur on the same byte; both take effect.
- Counters:
  - com_cnt and err_run saturate at their parameter values.
  - Widths are sized with $clog2 of the parameter plus 1.

## Timing
- Every output is registered and reflects the byte sampled on the previous rising edge of clk_4f, i.e. 1-cycle latency.
- shift_en, word_done and word_abort are single-cycle pulses. word_done only ever asserts together with shift_en.
- byte_out always follows data_in with 1-cycle delay, qualified or not. phase is meaningful only when shift_en = 1.
- active rises in the cycle after the LOCK_COUNT-th comma is sampled. It falls in the cycle after the LOSS_COUNT-th error event is sampled.
- Reset outputs are all 0: active, shift_en, byte_out, phase, word_done, word_abort, err_count.
- Asserting reset mid-word clears the state immediately and emits no word_abort.

## Configuration
- RX_SYNC_ERRCNT_EN defined:
  - err_count increments on every error event in LOCKED, plus every valid non-COM byte that resets CHECK.
  - It saturates at 8'hFF and clears only on reset.
- Not defined: err_count is constant 0, and its counter logic is absent.

## Test plan
- Lock acquisition: reset released, then 4 valid 8'hBC bytes -> active = 1 on the cycle after the 4th, with no shift_en.
- Broken acquisition: BC, BC, 8'h55, then 4 more BC -> no lock after the 8'h55; lock on the cycle after the 4th new BC. err_count = 1 with RX_SYNC_ERRCNT_EN.
- Word sequencing: locked, then 11, 22, 33, 44 -> four shift_en pulses with phase 0, 1, 2, 3 and byte_out 11..44. word_done coincides with 44.
- Abort mid-word: locked, then 11, 22, valid_in = 0 -> word_abort one cycle later with no shift_en. The next byte 77 shifts with phase 0; active stays 1.
- Loss of lock: locked, then valid_in = 0 for 4 cycles -> active = 0 on the cycle after the 4th. A following 8'h12 gives no shift_en.
- Reset mid-operation: locked at phase 2, then reset low for 1 cycle -> all outputs 0 and state SEARCH. 4 commas are needed to relock.
